perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Parametrised bank of NUM_CH hardware event counters with a memory-mapped read/clear interface on the CPU data port.
- Successor to the fixed nine-counter performance block.
- Adds per-channel cycle/event mode, runtime thresholds, sticky overflow status, global freeze and optional atomic snapshot.
- Sits beside the MEM stage: the datapath drives trigger lines and routes data accesses in the bank's address window here.

Parameters:
- NUM_CH, 9, number of counter channels (1..15)
- CNT_WIDTH, 16, counter width in bits (1..16); read data zero-extended to 16
- THRESH_WIDTH, 4, width of each per-channel threshold and run-length counter
- BASE_ADDR, 16'hFF00, word-aligned byte address of channel 0

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- trigger  in  NUM_CH  per-channel event input, bit i = channel i
- mode  in  NUM_CH  per-channel mode: 1 = cycle mode, 0 = event mode
- thresh  in  NUM_CH*THRESH_WIDTH  per-channel threshold, channel i at [i*THRESH_WIDTH +: THRESH_WIDTH]
- rd_en  in  1  MMIO read strobe
- wr_en  in  1  MMIO write strobe
- addr  in  16  MMIO byte address
- wdata  in  16  MMIO write data
- hit  out  1  addr is inside the window and (rd_en|wr_en)
- rdata  out  16  MMIO read data (combinational)
- ovf_any  out  1  OR of all sticky overflow bits

Behaviour:
- Address map, bit 0 of addr ignored:
  - BASE_ADDR+2*i: counter i
  - BASE_ADDR+2*NUM_CH: STATUS, overflow bits [NUM_CH-1:0]
  - BASE_ADDR+2*NUM_CH+2: CTRL, bit0 = freeze, bit1 = snapshot (see optional feature)
  - Any other address: hit=0, rdata=0.
- Reset (async, rst_n low): counters, run-length registers, overflow bits and freeze are 0. Outputs hit=0, rdata=0, ovf_any=0 while no access is presented.
- Cycle mode: count += 1 on every clock edge where trigger[i]=1 and freeze=0.
- Event mode:
  - run_len[i] counts prior consecutive high cycles and saturates at all-ones.
  - count += 1 on the edge where trigger[i]=1 && run_len[i]==thresh[i], so each run is counted at most once.
  - thresh=0 counts the first cycle of each run. thresh=2 counts a run only on its 3rd consecutive high cycle.
  - trigger low sets run_len to 0 at the next edge.
  - While frozen, run_len is held at 0.
- Arithmetic: counters are modulo 2^CNT_WIDTH. An increment from all-ones wraps to 0 and sets ovf[i] (sticky).
- Reads are combinational, with zero added latency: rdata = zero-extended count (or snapshot), STATUS, or CTRL value. Reads have no side effects.
- Writes take effect at the next edge:
  - Counter address: count <= wdata[CNT_WIDTH-1:0] and run_len is cleared.
  - STATUS: write-1-to-clear.
  - CTRL: bit0 loads freeze.
- Simultaneous write and increment on the same channel: the write wins and the increment is lost.
- Simultaneous overflow set and W1C on the same bit: the set wins.
- rd_en and wr_en both high: the write occurs, and rdata shows the pre-write value.
- Reset asserted mid-run: all state clears immediately. A run already in progress at deassertion is treated as new (run_len=0).
- mode or thresh changed mid-run: takes effect on the next edge. run_len is not cleared.

Optional Feature:
- Macro PERF_SNAPSHOT_EN.
- Defined:
  - Writing CTRL with bit1=1 copies all live counters into shadow registers at that edge. The bit self-clears and reads as 0.
  - Counter-address reads return the shadow value.
  - Shadows reset to 0.
  - Counter-address writes update the live counter only.
- Undefined: CTRL bit1 is ignored and reads 0, no shadow registers exist, and counter reads return live values.

Test Plan:
- Cycle mode ch0, trigger high 5 cycles, then read BASE_ADDR -> rdata=16'd5, hit=1.
- Event mode ch1, thresh=2, trigger runs of 1,2,3,6 cycles separated by lows -> count=2. With thresh=0, same stimulus -> count=4.
- CNT_WIDTH=4, ch2 cycle mode, 17 trigger cycles -> count=1, STATUS bit2=1, ovf_any=1. Write STATUS 16'h0004 -> STATUS=0, ovf_any=0.
- Write CTRL=1 (freeze), trigger all channels 10 cycles -> counts unchanged. Write CTRL=0 -> counting resumes next edge.
- Write counter ch0 = 16'h0000 in the same cycle trigger[0]=1 -> count=0 after the edge. Then assert rst_n=0 mid-run -> all reads 0 immediately.
- PERF_SNAPSHOT_EN defined: count ch0 to 7, write CTRL=2, trigger 3 more cycles, read ch0 -> 7. Snapshot again -> 10.

Source files
------------

// File: rtl/perf_counter_bank.sv
// NUM_CH event/cycle counters with MMIO read, write and clear; optional atomic snapshot under PERF_SNAPSHOT_EN.
// Reads are combinational, writes land on the next clk edge; no backpressure, the bank accepts every access.
module perf_counter_bank #(
  parameter int          NUM_CH       = 9,
  parameter int          CNT_WIDTH    = 16,
  parameter int          THRESH_WIDTH = 4,
  parameter logic [15:0] BASE_ADDR    = 16'hFF00
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              trigger,
  input  logic [NUM_CH-1:0]              mode,
  input  logic [NUM_CH*THRESH_WIDTH-1:0] thresh,
  input  logic                           rd_en,
  input  logic                           wr_en,
  input  logic [15:0]                    addr,
  input  logic [15:0]                    wdata,
  output logic                           hit,
  output logic [15:0]                    rdata,
  output logic                           ovf_any
);

  localparam logic [14:0] BASE_W   = BASE_ADDR[15:1];
  localparam logic [14:0] STATUS_W = 15'(NUM_CH);
  localparam logic [14:0] CTRL_W   = 15'(NUM_CH + 1);

  logic [CNT_WIDTH-1:0]    cnt     [NUM_CH];
  logic [CNT_WIDTH-1:0]    view    [NUM_CH];
  logic [THRESH_WIDTH-1:0] run_len [NUM_CH];
  logic [NUM_CH-1:0]       ovf;
  logic                    freeze;

  logic [14:0]       off;
  logic              in_win;
  logic              wr_status;
  logic              wr_ctrl;
  logic [NUM_CH-1:0] wr_ch;
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] ovf_set;
  logic [NUM_CH-1:0] ovf_clr;
  logic              addr_unused;

  // Word offset from the base; addresses below the base wrap high and fall outside.
  assign off         = addr[15:1] - BASE_W;
  assign in_win      = (addr[15:1] >= BASE_W) && (off <= CTRL_W);
  assign addr_unused = addr[0];

  assign hit       = in_win && (rd_en || wr_en);
  assign wr_status = wr_en && in_win && (off == STATUS_W);
  assign wr_ctrl   = wr_en && in_win && (off == CTRL_W);
  assign ovf_clr   = wr_status ? wdata[NUM_CH-1:0] : '0;
  assign ovf_any   = |ovf;

  always_comb begin
    wr_ch   = '0;
    inc     = '0;
    ovf_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ch[i]   = wr_en && in_win && (off == 15'(i));
      inc[i]     = trigger[i] && !freeze &&
                   (mode[i] || (run_len[i] == thresh[i*THRESH_WIDTH +: THRESH_WIDTH]));
      // A colliding counter write discards the increment, so it cannot wrap either.
      ovf_set[i] = inc[i] && !wr_ch[i] && (cnt[i] == {CNT_WIDTH{1'b1}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= '0;
        run_len[i] <= '0;
      end
      ovf    <= '0;
      freeze <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ch[i])
          cnt[i] <= wdata[CNT_WIDTH-1:0];
        else if (inc[i])
          cnt[i] <= cnt[i] + 1'b1;

        if (wr_ch[i] || freeze || !trigger[i])
          run_len[i] <= '0;
        else if (run_len[i] != {THRESH_WIDTH{1'b1}})
          run_len[i] <= run_len[i] + 1'b1;
      end
      // Set beats clear when both hit the same bit in one cycle.
      ovf <= (ovf & ~ovf_clr) | ovf_set;
      if (wr_ctrl)
        freeze <= wdata[0];
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] shadow [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++)
        shadow[i] <= '0;
    end else if (wr_ctrl && wdata[1]) begin
      for (int i = 0; i < NUM_CH; i++)
        shadow[i] <= cnt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      view[i] = shadow[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      view[i] = cnt[i];
  end
`endif

  // Snapshot bit is a strobe and always reads back as 0.
  always_comb begin
    rdata = '0;
    if (rd_en && in_win) begin
      if (off == STATUS_W)
        rdata = 16'(ovf);
      else if (off == CTRL_W)
        rdata = {15'b0, freeze};
      else begin
        for (int i = 0; i < NUM_CH; i++)
          if (off == 15'(i))
            rdata = 16'(view[i]);
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: expectations queued while stimulating, popped at each read.
module tb_perf_counter_bank;
  localparam int          NUM_CH = 9;
  localparam int          CW     = 4;
  localparam int          TW     = 4;
  localparam logic [15:0] BASE   = 16'hFF00;
  localparam logic [15:0] STAT_A = BASE + 16'(2*NUM_CH);
  localparam logic [15:0] CTRL_A = STAT_A + 16'd2;

  logic                   clk, rst_n;
  logic [NUM_CH-1:0]      trigger, mode;
  logic [NUM_CH*TW-1:0]   thresh;
  logic                   rd_en, wr_en;
  logic [15:0]            addr, wdata;
  logic                   hit, ovf_any;
  logic [15:0]            rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic        freeze_s = 1'b0;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW), .THRESH_WIDTH(TW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode), .thresh(thresh),
    .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .hit(hit), .rdata(rdata), .ovf_any(ovf_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks are entered and left just after a falling edge.
  task automatic mmio_wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic mmio_rd(input logic [15:0] a, output logic [15:0] d, output logic h);
    rd_en = 1'b1; addr = a;
    #1;
    d = rdata; h = hit;
    rd_en = 1'b0; addr = '0;
  endtask

  // Refresh shadows before counter reads when snapshots are built in.
  task automatic sync_view;
`ifdef PERF_SNAPSHOT_EN
    @(negedge clk);
    mmio_wr(CTRL_A, {14'b0, 1'b1, freeze_s});
`endif
  endtask

  task automatic drive_runs(input int ch);
    int lens[4] = '{1, 2, 3, 6};
    foreach (lens[k]) begin
      trigger[ch] = 1'b1;
      repeat (lens[k]) @(negedge clk);
      trigger[ch] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [15:0] d, e;
    logic        h;
    rst_n = 1'b0;
    #12;
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", hit); end
    n_tests++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    n_tests++; if (ovf_any !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_any: got %b expected 0", ovf_any); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NUM_CH + 2; i++) begin
      exp_q.push_back(16'h0);
      mmio_rd(BASE + 16'(2*i), d, h);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL reset_word%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_cycle;
    logic [15:0] d, e;
    logic        h;
    @(negedge clk);
    mode = 9'h001;
    trigger[0] = 1'b1;
    repeat (5) @(negedge clk);
    trigger[0] = 1'b0;
    exp_q.push_back(16'd5); exp_q.push_back(16'd5); exp_q.push_back(16'd0);
    sync_view;
    mmio_rd(BASE, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL cycle_ch0: got %h expected %h", d, e); end
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL cycle_hit: got %b expected 1", h); end
    mmio_rd(BASE + 16'd1, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL cycle_addr_bit0: got %h expected %h", d, e); end
    mmio_rd(BASE + 16'd2, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL cycle_ch1_idle: got %h expected %h", d, e); end
  endtask

  task automatic test_event;
    logic [15:0] d, e;
    logic        h;
    @(negedge clk);
    mode = '0;
    thresh = '0;
    thresh[1*TW +: TW] = 4'd2;
    exp_q.push_back(16'd2);
    drive_runs(1);
    sync_view;
    mmio_rd(BASE + 16'd2, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL event_thresh2: got %h expected %h", d, e); end
    @(negedge clk);
    mmio_wr(BASE + 16'd2, 16'h0);
    thresh[1*TW +: TW] = 4'd0;
    exp_q.push_back(16'd4);
    drive_runs(1);
    sync_view;
    mmio_rd(BASE + 16'd2, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL event_thresh0: got %h expected %h", d, e); end
  endtask

  task automatic test_overflow;
    logic [15:0] d, e;
    logic        h;
    @(negedge clk);
    mode = 9'h004;
    trigger[2] = 1'b1;
    repeat (17) @(negedge clk);
    trigger[2] = 1'b0;
    exp_q.push_back(16'd1); exp_q.push_back(16'h0004);
    sync_view;
    mmio_rd(BASE + 16'd4, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL ovf_count: got %h expected %h", d, e); end
    mmio_rd(STAT_A, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL ovf_status: got %h expected %h", d, e); end
    n_tests++; if (ovf_any !== 1'b1) begin n_fail++; $display("FAIL ovf_any_set: got %b expected 1", ovf_any); end
    @(negedge clk);
    mmio_wr(STAT_A, 16'h0004);
    exp_q.push_back(16'h0);
    mmio_rd(STAT_A, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL ovf_w1c: got %h expected %h", d, e); end
    n_tests++; if (ovf_any !== 1'b0) begin n_fail++; $display("FAIL ovf_any_clr: got %b expected 0", ovf_any); end
  endtask

  task automatic test_freeze;
    logic [15:0] d, e;
    logic        h;
    @(negedge clk);
    mode = '1;
    for (int i = 0; i < NUM_CH; i++) mmio_wr(BASE + 16'(2*i), 16'(i + 1));
    mmio_wr(CTRL_A, 16'h0001);
    freeze_s = 1'b1;
    exp_q.push_back(16'h0001);
    mmio_rd(CTRL_A, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL freeze_ctrl: got %h expected %h", d, e); end
    @(negedge clk);
    trigger = '1;
    repeat (10) @(negedge clk);
    trigger = '0;
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(16'(i + 1));
    sync_view;
    for (int i = 0; i < NUM_CH; i++) begin
      mmio_rd(BASE + 16'(2*i), d, h);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL freeze_hold_ch%0d: got %h expected %h", i, d, e); end
    end
    // Unfreeze edge itself must not count; exactly one edge follows with triggers high.
    @(negedge clk);
    trigger = '1;
    mmio_wr(CTRL_A, 16'h0000);
    freeze_s = 1'b0;
    @(negedge clk);
    trigger = '0;
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(16'(i + 2));
    sync_view;
    for (int i = 0; i < NUM_CH; i++) begin
      mmio_rd(BASE + 16'(2*i), d, h);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL freeze_resume_ch%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_collision;
    logic [15:0] d, e;
    logic        h;
    @(negedge clk);
    mode = 9'h005;
    mmio_wr(BASE, 16'd3);
    sync_view;
    @(negedge clk);
    exp_q.push_back(16'd3); exp_q.push_back(16'd0);
    trigger[0] = 1'b1;
    wr_en = 1'b1; rd_en = 1'b1; addr = BASE; wdata = 16'h0;
    #1;
    d = rdata;
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL rdwr_prewrite: got %h expected %h", d, e); end
    @(negedge clk);
    trigger[0] = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0;
    sync_view;
    mmio_rd(BASE, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL write_beats_inc: got %h expected %h", d, e); end
    @(negedge clk);
    mmio_wr(BASE + 16'd4, 16'h000F);
    trigger[2] = 1'b1;
    mmio_wr(STAT_A, 16'h0004);
    trigger[2] = 1'b0;
    exp_q.push_back(16'h0004);
    mmio_rd(STAT_A, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL set_beats_w1c: got %h expected %h", d, e); end
    @(negedge clk);
    mmio_wr(STAT_A, 16'h0004);
  endtask

  task automatic test_window;
    logic [15:0] d;
    logic        h;
    logic [15:0] outs[3] = '{BASE - 16'd2, CTRL_A + 16'd2, 16'h0000};
    @(negedge clk);
    foreach (outs[k]) begin
      exp_q.push_back(16'h0);
      mmio_rd(outs[k], d, h);
      n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL window_hit_%0d: got %b expected 0", k, h); end
      n_tests++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL window_rdata_%0d: got %h expected %h", k, d, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d, e;
    logic        h, t3, t4;
    int          m3, m4, r4, ov;
    @(negedge clk);
    mode = 9'h008;
    thresh = '0;
    thresh[4*TW +: TW] = 4'd1;
    mmio_wr(BASE + 16'd6, 16'h0);
    mmio_wr(BASE + 16'd8, 16'h0);
    m3 = 0; m4 = 0; r4 = 0; ov = 0;
    for (int round = 0; round < 3; round++) begin
      for (int c = 0; c < 20; c++) begin
        t3 = 1'($urandom_range(0, 3) != 0);
        t4 = 1'($urandom_range(0, 1));
        trigger[3] = t3; trigger[4] = t4;
        if (t3) begin
          if (m3 == 15) ov = 1;
          m3 = (m3 + 1) % 16;
        end
        if (t4 && r4 == 1) m4 = (m4 + 1) % 16;
        r4 = t4 ? ((r4 == 15) ? 15 : r4 + 1) : 0;
        @(negedge clk);
      end
      trigger = '0;
      r4 = 0;
      exp_q.push_back(16'(m3)); exp_q.push_back(16'(m4)); exp_q.push_back(ov ? 16'h0008 : 16'h0);
      sync_view;
      mmio_rd(BASE + 16'd6, d, h);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL b2b_ch3_r%0d: got %h expected %h", round, d, e); end
      mmio_rd(BASE + 16'd8, d, h);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL b2b_ch4_r%0d: got %h expected %h", round, d, e); end
      mmio_rd(STAT_A, d, h);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL b2b_status_r%0d: got %h expected %h", round, d, e); end
      @(negedge clk);
    end
    mmio_wr(STAT_A, 16'h01FF);
  endtask

  task automatic test_snapshot;
    logic [15:0] d, e;
    logic        h;
    @(negedge clk);
    mode = 9'h001;
    mmio_wr(BASE, 16'h0);
    trigger[0] = 1'b1;
    repeat (7) @(negedge clk);
    trigger[0] = 1'b0;
    mmio_wr(CTRL_A, 16'h0002);
    trigger[0] = 1'b1;
    repeat (3) @(negedge clk);
    trigger[0] = 1'b0;
`ifdef PERF_SNAPSHOT_EN
    exp_q.push_back(16'd7);
`else
    exp_q.push_back(16'd10);
`endif
    exp_q.push_back(16'h0);
    mmio_rd(BASE, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL snap_first: got %h expected %h", d, e); end
    mmio_rd(CTRL_A, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL snap_ctrl_bit1: got %h expected %h", d, e); end
    @(negedge clk);
    mmio_wr(CTRL_A, 16'h0002);
    mmio_wr(BASE, 16'd5);
`ifdef PERF_SNAPSHOT_EN
    exp_q.push_back(16'd10);
`else
    exp_q.push_back(16'd5);
`endif
    mmio_rd(BASE, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL snap_second: got %h expected %h", d, e); end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] d, e;
    logic        h;
    @(negedge clk);
    mode = 9'h001;
    thresh = '0;
    trigger = 9'h003;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NUM_CH + 2; i++) begin
      exp_q.push_back(16'h0);
      mmio_rd(BASE + 16'(2*i), d, h);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL midrst_word%0d: got %h expected %h", i, d, e); end
    end
    n_tests++; if (ovf_any !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf_any: got %b expected 0", ovf_any); end
    freeze_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    trigger = '0;
    exp_q.push_back(16'd3); exp_q.push_back(16'd1);
    sync_view;
    mmio_rd(BASE, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL midrst_ch0_after: got %h expected %h", d, e); end
    mmio_rd(BASE + 16'd2, d, h);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL midrst_new_run: got %h expected %h", d, e); end
  endtask

  initial begin
    trigger = '0; mode = '0; thresh = '0;
    rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    test_reset();
    test_cycle();
    test_event();
    test_overflow();
    test_freeze();
    test_collision();
    test_window();
    test_back_to_back();
    test_snapshot();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
